block_transfer_seq: RTL and testbench
=====================================

# block_transfer_seq

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It shares the 16-entry register file and the single data-memory port across one multiple-register instruction. It walks a 16-bit register list in ascending order and drives register-file read/write addresses, memory requests and base-register writeback. It sits between the decoder/control unit, which issues START, and the register file and data memory.

## Interface
- No parameters; data width is fixed at 32 bits and register index width at 4 bits.
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin transfer; sampled only in IDLE.
- LOAD  in  1  1 = LDM (memory -> registers), 0 = STM.
- UP  in  1  1 = increment (IA/IB), 0 = decrement (DA/DB).
- PRE  in  1  1 = before (IB/DB), 0 = after (IA/DA).
- WB  in  1  write the final base back to RN.
- RN  in  4  base register index.
- BASE  in  32  base register value, sampled with START.
- RLIST  in  16  register list; bit i selects Ri. Sampled with START.
- RF_RD1  in  32  register-file read data for RF_A1 (R15 is already substituted upstream).
- MEM_RDATA  in  32  memory read data, valid when MEM_READY is high.
- MEM_READY  in  1  memory accepts or completes the current request this cycle.
- RF_A1  out  4  read address of the register being stored.
- RF_A3  out  4  write address.
- RF_WD3  out  32  write data.
- RF_WE3  out  1  register-file write enable.
- PC_WE  out  1  load of R15; data is on RF_WD3. RF_WE3 is not asserted for R15.
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  store request (MEM_REQ & ~LOAD).
- MEM_ADDR  out  32  word address of the current transfer.
- MEM_WDATA  out  32  equals RF_RD1.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE -> XFER when START is high and RLIST != 0.
  - IDLE -> DONE when START is high and RLIST == 0.
  - XFER -> WBACK on the last accepted transfer when a writeback is due.
  - XFER -> DONE on the last accepted transfer otherwise.
  - WBACK -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
- On START, latch the controls. Compute N = popcount(RLIST), range 1..16.
- Start address by mode:
  - IA: BASE
  - IB: BASE+4
  - DA: BASE-4N+4
  - DB: BASE-4N
- Final base = BASE ± 4N. All arithmetic is modulo 2^32.
- Transfer order: the current register is the lowest set bit of the remaining mask. The lowest register always goes to the lowest address.
- XFER drives MEM_REQ=1, MEM_ADDR = current address and RF_A1 = current register.
- A transfer is accepted in a cycle where MEM_REQ and MEM_READY are both high. On acceptance: clear the mask bit and add 4 to the address.
- LDM acceptance writes in the same cycle, combinationally, with RF_WD3 = MEM_RDATA:
  - current register != 15: RF_WE3=1, RF_A3 = current register.
  - current register == 15: PC_WE=1, RF_WE3=0.
- STM: MEM_WE=1 and MEM_WDATA=RF_RD1. The register file is not written.
- Writeback is due when WB=1, except on LDM with RLIST[RN]=1 (the loaded value wins; skip WBACK).
- WBACK: RF_WE3=1, RF_A3=RN, RF_WD3 = final base, MEM_REQ=0.
- START while BUSY is ignored.
- RLIST == 0: no memory access, no writeback, DONE only.

## Timing
- Reset value of every output is 0; the FSM enters IDLE and the mask is cleared.
- RESET mid-transfer aborts at the next edge:
  - No further MEM_REQ, RF_WE3 or PC_WE.
  - No writeback is issued.
  - Writes already accepted stand.
- START sampled in cycle T. The first MEM_REQ is in cycle T+1.
- Each transfer takes 1 + k cycles, where k is the number of cycles MEM_READY is low while requested.
- MEM_ADDR, MEM_WE and MEM_WDATA stay stable while MEM_REQ is high and MEM_READY is low.
- With MEM_READY held high, latency from START to DONE is:
  - N+1 cycles without writeback.
  - N+2 cycles with writeback.
  - 1 cycle for RLIST == 0.
- A new START is accepted in the cycle after DONE.

## Test plan
- STM IA, RN=13, BASE=0x1000, RLIST=0x0016, WB=1, MEM_READY=1:
  - Stores R1@0x1000, R2@0x1004, R4@0x1008.
  - T+4: RF_WE3 with R13 <- 0x100C.
  - T+5: DONE.
- LDM DB, BASE=0x2000, RLIST=0x8001, WB=0:
  - R0 loaded from 0x1FF8 with RF_WE3.
  - R15 loaded from 0x1FFC with PC_WE=1 and RF_WE3=0.
  - No WBACK.
- LDM IA, RN=2, RLIST=0x0006, WB=1: R1 and R2 are loaded; WBACK is skipped; R2 holds the loaded value.
- STM DA, BASE=0x0, RLIST=0x0001, MEM_READY low for 3 cycles:
  - Address wraps to 0x0000_0000, since BASE-4N+4 = 0.
  - The request is held stable for 4 cycles.
  - DONE follows.
- RLIST=0: DONE at T+1 with no MEM_REQ. A second START while BUSY is ignored.
- RESET asserted in the 2nd XFER cycle of a 4-register LDM: the next cycle has all outputs 0 and the FSM in IDLE; no writeback occurs.

Source files
------------

// File: rtl/block_transfer_seq_if.sv
// block_transfer_seq_if
//
// Groups the control, register-file and data-memory signals of the LDM/STM
// block transfer sequencer.
//
// master modport (the sequencer):
//   in : start, load, up, pre, wb, rn[3:0], base[31:0], rlist[15:0],
//        rf_rd1[31:0], mem_rdata[31:0], mem_ready
//   out: rf_a1[3:0], rf_a3[3:0], rf_wd3[31:0], rf_we3, pc_we, mem_req,
//        mem_we, mem_addr[31:0], mem_wdata[31:0], busy, done
// slave modport: the same signals with the opposite directions, for the
// decoder / register file / memory side.
interface block_transfer_seq_if;
    logic        start;
    logic        load;
    logic        up;
    logic        pre;
    logic        wb;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] rlist;
    logic [31:0] rf_rd1;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [3:0]  rf_a1;
    logic [3:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we3;
    logic        pc_we;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;

    modport master (
        input  start, load, up, pre, wb, rn, base, rlist,
               rf_rd1, mem_rdata, mem_ready,
        output rf_a1, rf_a3, rf_wd3, rf_we3, pc_we, mem_req,
               mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        output start, load, up, pre, wb, rn, base, rlist,
               rf_rd1, mem_rdata, mem_ready,
        input  rf_a1, rf_a3, rf_wd3, rf_we3, pc_we, mem_req,
               mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/block_transfer_seq.sv
// block_transfer_seq
//
// Multi-cycle sequencer for ARM LDM/STM. Walks the register list from the
// lowest set bit upwards, issuing one memory transfer per register on the
// shared data port, then optionally writes the updated base back to RN.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    block_transfer_seq_if.master (controls, register-file and memory
//          signals; see the interface file for the full list)
module block_transfer_seq (
    input  logic                 clk,
    input  logic                 reset,
    block_transfer_seq_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WBACK,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] mask;
    logic [31:0] addr;
    logic [31:0] final_base;
    logic        load_q;
    logic [3:0]  rn_q;
    logic        wb_due_q;

    logic [4:0]  count;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [31:0] end_base;
    logic [3:0]  cur;
    logic        accept;
    logic        last;

    // Number of registers in the incoming list and the start / final base
    // addresses for the selected addressing mode. The lowest register always
    // lands on the lowest address, so decrementing modes start low and still
    // walk upwards.
    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'b0, bus.rlist[i]};
        end
        four_n = {25'b0, count, 2'b00};
        case ({bus.up, bus.pre})
            2'b10:   start_addr = bus.base;
            2'b11:   start_addr = bus.base + 32'd4;
            2'b00:   start_addr = bus.base - four_n + 32'd4;
            default: start_addr = bus.base - four_n;
        endcase
        end_base = bus.up ? (bus.base + four_n) : (bus.base - four_n);
    end

    // The register being transferred is the lowest set bit still in the mask;
    // the transfer completes when the memory is ready in an XFER cycle.
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                cur = 4'(i);
            end
        end
        accept = (state == S_XFER) && bus.mem_ready;
        last   = (mask & (mask - 16'd1)) == 16'd0;
    end

    // State register plus the per-instruction context latched on START.
    // Writeback is suppressed when an LDM also loads the base register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mask       <= '0;
            addr       <= '0;
            final_base <= '0;
            load_q     <= 1'b0;
            rn_q       <= '0;
            wb_due_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && bus.start) begin
                mask       <= bus.rlist;
                addr       <= start_addr;
                final_base <= end_base;
                load_q     <= bus.load;
                rn_q       <= bus.rn;
                wb_due_q   <= bus.wb & ~(bus.load & bus.rlist[bus.rn]);
            end else if (accept) begin
                mask <= mask & ~(16'd1 << cur);
                addr <= addr + 32'd4;
            end
        end
    end

    // Next-state and output decode. Outputs are zero outside the states that
    // use them, so idle and reset present an all-zero interface. LDM data is
    // written to the register file in the same cycle the memory completes.
    always_comb begin
        state_next    = state;
        bus.rf_a1     = '0;
        bus.rf_a3     = '0;
        bus.rf_wd3    = '0;
        bus.rf_we3    = 1'b0;
        bus.pc_we     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = (state != S_IDLE);
        bus.done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.rlist != 16'd0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr;
                bus.rf_a1    = cur;
                if (!load_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.rf_rd1;
                end
                if (accept) begin
                    if (load_q) begin
                        bus.rf_wd3 = bus.mem_rdata;
                        if (cur == 4'd15) begin
                            bus.pc_we = 1'b1;
                        end else begin
                            bus.rf_we3 = 1'b1;
                            bus.rf_a3  = cur;
                        end
                    end
                    if (last) begin
                        state_next = wb_due_q ? S_WBACK : S_DONE;
                    end
                end
            end
            S_WBACK: begin
                bus.rf_we3 = 1'b1;
                bus.rf_a3  = rn_q;
                bus.rf_wd3 = final_base;
                state_next = S_DONE;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_transfer_seq.sv
// tb_block_transfer_seq
//
// Self-checking bench for block_transfer_seq: a table of directed LDM/STM
// instructions, randomized instructions with random memory stalls, and a
// reset-abort sequence. Expected behaviour comes from a transaction-level
// model that lists (register, address) pairs for each instruction.
module tb_block_transfer_seq;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    block_transfer_seq_if bus();

    block_transfer_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] lastRdata;
    logic [31:0] lastRd1;
    logic [31:0] shadow    [16];
    logic [31:0] loadedVal [16];

    logic [31:0] obsFirstAddr;
    logic [31:0] obsWbData;
    logic        obsSawWb;
    int          obsLatency;

    typedef struct {
        logic        l;
        logic        u;
        logic        p;
        logic        w;
        logic [3:0]  rn;
        logic [31:0] base;
        logic [15:0] rlist;
        int          lowPer;
        logic        expMem;
        logic [31:0] expFirst;
        logic        expWb;
        logic [31:0] expWbData;
        int          expLat;
    } vec_t;

    vec_t vecs [9];

    // Register file as seen from the sequencer's write port
    always @(posedge clk) begin
        if (bus.rf_we3) begin
            shadow[bus.rf_a3] <= bus.rf_wd3;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic u, input logic p,
                                 input logic w, input logic [3:0] r, input logic [31:0] b,
                                 input logic [15:0] rl, input logic rdy);
        bus.start     = s;
        bus.load      = l;
        bus.up        = u;
        bus.pre       = p;
        bus.wb        = w;
        bus.rn        = r;
        bus.base      = b;
        bus.rlist     = rl;
        bus.mem_ready = rdy;
        lastRdata     = $urandom;
        lastRd1       = $urandom;
        bus.mem_rdata = lastRdata;
        bus.rf_rd1    = lastRd1;
    endtask

    // While busy, keep START high with junk controls: all of it must be ignored
    task automatic busyStimulus(input logic rdy);
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom), $urandom, 16'($urandom) | 16'd1, rdy);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".mem_req"},   32'(bus.mem_req),   32'd0);
        checkOutput({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
        checkOutput({tag, ".mem_addr"},  bus.mem_addr,       32'd0);
        checkOutput({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
        checkOutput({tag, ".rf_we3"},    32'(bus.rf_we3),    32'd0);
        checkOutput({tag, ".pc_we"},     32'(bus.pc_we),     32'd0);
        checkOutput({tag, ".rf_a1"},     32'(bus.rf_a1),     32'd0);
        checkOutput({tag, ".rf_a3"},     32'(bus.rf_a3),     32'd0);
        checkOutput({tag, ".rf_wd3"},    bus.rf_wd3,         32'd0);
        checkOutput({tag, ".busy"},      32'(bus.busy),      32'd0);
        checkOutput({tag, ".done"},      32'(bus.done),      32'd0);
    endtask

    // One complete instruction, cycle by cycle, against the reference model.
    // lowPerXfer >= 0 holds mem_ready low that many cycles per transfer;
    // a negative value gives random stalls of at most 4 cycles.
    task automatic runTransaction(input logic l, input logic u, input logic p, input logic w,
                                  input logic [3:0] r, input logic [31:0] b,
                                  input logic [15:0] rl, input int lowPerXfer);
        int          n;
        int          k;
        int          cyc;
        int          lows;
        logic        rdy;
        logic        wbDue;
        logic [31:0] lowAddr;
        logic [31:0] finalB;
        int          regList  [16];
        logic [31:0] addrList [16];

        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) n++;
        end
        if (u) lowAddr = p ? b + 32'd4 : b;
        else   lowAddr = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        finalB = u ? b + 32'(4 * n) : b - 32'(4 * n);
        wbDue  = w && !(l && rl[r]) && (n != 0);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                regList[k]  = i;
                addrList[k] = lowAddr + 32'(4 * k);
                k++;
            end
        end

        obsFirstAddr = 32'hDEAD_BEEF;
        obsWbData    = 32'hDEAD_BEEF;
        obsSawWb     = 1'b0;
        obsLatency   = -1;

        @(negedge clk);
        applyStimulus(1'b1, l, u, p, w, r, b, rl, 1'b1);
        #1;
        checkOutput("idle.busy",    32'(bus.busy),    32'd0);
        checkOutput("idle.done",    32'(bus.done),    32'd0);
        checkOutput("idle.mem_req", 32'(bus.mem_req), 32'd0);
        cyc = 0;

        for (int x = 0; x < n; x++) begin
            lows = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (lowPerXfer >= 0) rdy = (lows >= lowPerXfer);
                else                 rdy = (lows >= 4) || ($urandom_range(0, 2) != 0);
                busyStimulus(rdy);
                #1;
                if (x == 0 && lows == 0) obsFirstAddr = bus.mem_addr;
                checkOutput("xfer.mem_req",  32'(bus.mem_req), 32'd1);
                checkOutput("xfer.mem_addr", bus.mem_addr,     addrList[x]);
                checkOutput("xfer.rf_a1",    32'(bus.rf_a1),   32'(regList[x]));
                checkOutput("xfer.mem_we",   32'(bus.mem_we),  32'(!l));
                checkOutput("xfer.busy",     32'(bus.busy),    32'd1);
                checkOutput("xfer.done",     32'(bus.done),    32'd0);
                if (!l) checkOutput("xfer.mem_wdata", bus.mem_wdata, lastRd1);
                if (rdy && l) begin
                    checkOutput("ldm.rf_we3", 32'(bus.rf_we3), 32'(regList[x] != 15));
                    checkOutput("ldm.pc_we",  32'(bus.pc_we),  32'(regList[x] == 15));
                    checkOutput("ldm.rf_wd3", bus.rf_wd3,      lastRdata);
                    if (regList[x] != 15) checkOutput("ldm.rf_a3", 32'(bus.rf_a3), 32'(regList[x]));
                    loadedVal[regList[x]] = lastRdata;
                end else begin
                    checkOutput("xfer.rf_we3", 32'(bus.rf_we3), 32'd0);
                    checkOutput("xfer.pc_we",  32'(bus.pc_we),  32'd0);
                end
                lows++;
            end while (!rdy);
        end

        if (wbDue) begin
            @(negedge clk);
            cyc++;
            busyStimulus(1'b1);
            #1;
            checkOutput("wback.rf_we3",  32'(bus.rf_we3),  32'd1);
            checkOutput("wback.rf_a3",   32'(bus.rf_a3),   32'(r));
            checkOutput("wback.rf_wd3",  bus.rf_wd3,       finalB);
            checkOutput("wback.mem_req", 32'(bus.mem_req), 32'd0);
            checkOutput("wback.pc_we",   32'(bus.pc_we),   32'd0);
            obsWbData = bus.rf_wd3;
            obsSawWb  = bus.rf_we3 && !bus.mem_req && !bus.done;
        end

        @(negedge clk);
        cyc++;
        busyStimulus(1'b1);
        #1;
        checkOutput("done.done",    32'(bus.done),    32'd1);
        checkOutput("done.busy",    32'(bus.busy),    32'd1);
        checkOutput("done.mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("done.rf_we3",  32'(bus.rf_we3),  32'd0);
        if (bus.done) obsLatency = cyc;
    endtask

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed table, random instructions, then the reset-abort sequence
    initial begin
        logic [31:0] keep9;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_1000, 16'h0016, 0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_100C, 5};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  32'h0000_2000, 16'h8001, 0, 1'b1, 32'h0000_1FF8, 1'b0, 32'h0,         3};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0000_3000, 16'h0006, 0, 1'b1, 32'h0000_3000, 1'b0, 32'h0,         3};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  32'h0000_0000, 16'h0001, 3, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd1,  32'h0000_0500, 16'h0000, 0, 1'b0, 32'h0,         1'b0, 32'h0,         1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  32'hFFFF_FFF8, 16'h0003, 0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 4};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  32'h0000_0100, 16'hFFFF, 0, 1'b1, 32'h0000_00C0, 1'b0, 32'h0,         17};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  32'h0000_0010, 16'h8000, 0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C, 3};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  32'h0000_0040, 16'h0030, 1, 1'b1, 32'h0000_003C, 1'b1, 32'h0000_0038, 6};

        for (int i = 0; i < 16; i++) begin
            shadow[i]    = 32'd0;
            loadedVal[i] = 32'd0;
        end

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            runTransaction(vecs[v].l, vecs[v].u, vecs[v].p, vecs[v].w, vecs[v].rn,
                           vecs[v].base, vecs[v].rlist, vecs[v].lowPer);
            if (vecs[v].expMem) checkOutput($sformatf("vec%0d.firstAddr", v), obsFirstAddr, vecs[v].expFirst);
            checkOutput($sformatf("vec%0d.sawWb", v), 32'(obsSawWb), 32'(vecs[v].expWb));
            if (vecs[v].expWb) checkOutput($sformatf("vec%0d.wbData", v), obsWbData, vecs[v].expWbData);
            checkOutput($sformatf("vec%0d.latency", v), 32'(obsLatency), 32'(vecs[v].expLat));
            if (v == 0) checkOutput("vec0.r13", shadow[13], 32'h0000_100C);
            if (v == 2) checkOutput("vec2.r2",  shadow[2],  loadedVal[2]);
        end

        repeat (25) begin
            runTransaction(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                           $urandom,
                           ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom), -1);
        end

        // Reset during the second transfer of a 4-register LDM with writeback
        keep9 = shadow[9];
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_4000, 16'h00F0, 1'b1);
        @(negedge clk);
        busyStimulus(1'b1);
        #1;
        checkOutput("abort.xfer1.addr", bus.mem_addr, 32'h0000_4000);
        @(negedge clk);
        busyStimulus(1'b1);
        reset = 1'b1;
        #1;
        checkOutput("abort.xfer2.addr",   bus.mem_addr,     32'h0000_4004);
        checkOutput("abort.xfer2.rf_a3",  32'(bus.rf_a3),   32'd5);
        checkOutput("abort.xfer2.rf_we3", 32'(bus.rf_we3),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0, 1'b1);
        #1;
        checkAllZero("abort");
        repeat (4) begin
            @(negedge clk);
            #1;
            checkOutput("abort.quiet.rf_we3",  32'(bus.rf_we3),  32'd0);
            checkOutput("abort.quiet.mem_req", 32'(bus.mem_req), 32'd0);
            checkOutput("abort.quiet.busy",    32'(bus.busy),    32'd0);
        end
        checkOutput("abort.r9", shadow[9], keep9);

        runTransaction(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 32'h0000_8000, 16'h0A05, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
